// File: rtl/sram_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_ctrl_if
// Brief    : Request/response and SRAM byte-row bus bundle for sram_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_access_ctrl_if #(
    parameter int ADDR_W = 4
);
    localparam int c_NUM_ROWS = 2 ** ADDR_W;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [7:0]            req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [7:0]            rsp_rdata;
    logic                  rsp_err;
    logic [c_NUM_ROWS-1:0] wl;
    logic [7:0]            sram_datain;
    logic [7:0]            sram_dataout;
    logic                  read_pulse;
    logic                  write_pulse;

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_dataout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, wl, sram_datain,
               read_pulse, write_pulse
    );

    // Requester plus SRAM array side.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_dataout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, wl, sram_datain,
               read_pulse, write_pulse
    );
endinterface
`default_nettype wire

// File: rtl/sram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_ctrl
// Brief    : Sequences SETUP/PULSE/HOLD accesses into SRAM byte rows behind a
//            valid/ready request/response port. Optional macro
//            SRAM_WRITE_VERIFY_EN adds a read-back verify pass after writes.
// Revision : 1.0 - initial release
// ============================================================================
module sram_access_ctrl #(
    parameter int ADDR_W       = 4,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    sram_access_ctrl_if.slave bus
);
    localparam int c_NUM_ROWS = 2 ** ADDR_W;
    localparam int c_CNT_W    = 16;
    localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(PULSE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(HOLD_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_PULSE = 3'd2;
    localparam logic [2:0] c_ST_HOLD  = 3'd3;
    localparam logic [2:0] c_ST_RESP  = 3'd4;

    logic [2:0]            r_state,     w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt,       w_cnt_nxt;
    logic                  r_verify,    w_verify_nxt;
    logic [ADDR_W-1:0]     r_addr,      w_addr_nxt;
    logic                  r_we,        w_we_nxt;
    logic [7:0]            r_wdata,     w_wdata_nxt;
    logic [c_NUM_ROWS-1:0] r_wl,        w_wl_nxt;
    logic [7:0]            r_datain,    w_datain_nxt;
    logic                  r_rpulse,    w_rpulse_nxt;
    logic                  r_wpulse,    w_wpulse_nxt;
    logic                  r_req_ready, w_req_ready_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic [7:0]            r_rsp_rdata, w_rsp_rdata_nxt;
    logic                  r_rsp_err,   w_rsp_err_nxt;
    logic                  w_is_read;
    logic                  w_in_access;

    // The verify pass of a write is electrically a read.
    assign w_is_read = !r_we || r_verify;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_verify    <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_wl        <= '0;
            r_datain    <= '0;
            r_rpulse    <= 1'b0;
            r_wpulse    <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_verify    <= w_verify_nxt;
            r_addr      <= w_addr_nxt;
            r_we        <= w_we_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wl        <= w_wl_nxt;
            r_datain    <= w_datain_nxt;
            r_rpulse    <= w_rpulse_nxt;
            r_wpulse    <= w_wpulse_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    // Outputs are registered from the next state so each phase shows up
    // on the pins in the same cycle the FSM occupies it.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_verify_nxt    = r_verify;
        w_addr_nxt      = r_addr;
        w_we_nxt        = r_we;
        w_wdata_nxt     = r_wdata;
        w_datain_nxt    = r_datain;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.req_valid && r_req_ready) begin
                    w_state_nxt     = c_ST_SETUP;
                    w_cnt_nxt       = '0;
                    w_verify_nxt    = 1'b0;
                    w_addr_nxt      = bus.req_addr;
                    w_we_nxt        = bus.req_we;
                    w_wdata_nxt     = bus.req_wdata;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b0;
                    if (bus.req_we) begin
                        w_datain_nxt = bus.req_wdata;
                    end
                end
            end
            c_ST_SETUP: begin
                if (r_cnt == c_SETUP_LAST) begin
                    w_state_nxt = c_ST_PULSE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_PULSE: begin
                if (r_cnt == c_PULSE_LAST) begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_nxt   = '0;
                    if (w_is_read) begin
                        if (r_verify) begin
                            w_rsp_err_nxt = (bus.sram_dataout != r_wdata);
                        end else begin
                            w_rsp_rdata_nxt = bus.sram_dataout;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_HOLD: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_cnt_nxt = '0;
`ifdef SRAM_WRITE_VERIFY_EN
                    if (r_we && !r_verify) begin
                        w_state_nxt  = c_ST_SETUP;
                        w_verify_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = c_ST_RESP;
                        w_rsp_valid_nxt = 1'b1;
                    end
`else
                    w_state_nxt     = c_ST_RESP;
                    w_rsp_valid_nxt = 1'b1;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_RESP: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_state_nxt     = c_ST_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        w_in_access     = (w_state_nxt == c_ST_SETUP) || (w_state_nxt == c_ST_PULSE) ||
                          (w_state_nxt == c_ST_HOLD);
        w_wl_nxt        = w_in_access ? (c_NUM_ROWS'(1) << w_addr_nxt) : '0;
        w_rpulse_nxt    = (w_state_nxt == c_ST_PULSE) && (!w_we_nxt || w_verify_nxt);
        w_wpulse_nxt    = (w_state_nxt == c_ST_PULSE) && w_we_nxt && !w_verify_nxt;
        w_req_ready_nxt = (w_state_nxt == c_ST_IDLE);
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.wl          = r_wl;
    assign bus.sram_datain = r_datain;
    assign bus.read_pulse  = r_rpulse;
    assign bus.write_pulse = r_wpulse;
endmodule
`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_access_ctrl
// Brief    : Self-checking bench for sram_access_ctrl with a byte-row array
//            model and a behavioural reference (latency, data, strobes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_access_ctrl;
    localparam int S = 1;
    localparam int P = 2;
    localparam int H = 1;
`ifdef SRAM_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   cyc;
    logic stuck_b0;
    logic [7:0] mem [16] = '{default: 8'h00};
    logic [7:0] ref_mem [16] = '{default: 8'h00};

    sram_access_ctrl_if #(.ADDR_W(4)) bus ();

    sram_access_ctrl #(
        .ADDR_W(4), .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Byte-row array: rows respond to their wordline and the strobes.
    always_comb begin
        bus.sram_dataout = 8'h00;
        for (int i = 0; i < 16; i++)
            if (bus.read_pulse && bus.wl[i]) bus.sram_dataout = mem[i];
    end
    always @(posedge clk)
        for (int i = 0; i < 16; i++)
            if (bus.write_pulse && bus.wl[i])
                mem[i] <= stuck_b0 ? (bus.sram_datain & 8'hFE) : bus.sram_datain;

    function automatic int exp_lat(input logic we);
        return (we && VERIFY) ? 2 * (S + P + H) + 1 : S + P + H + 1;
    endfunction

    // Drives one request and reports what was observed; callers judge it.
    task automatic do_access(input logic we, input logic [3:0] addr, input logic [7:0] wdata,
                             input int hold, output int lat, output logic [7:0] rdata,
                             output logic err, output int wp, output int rp,
                             output logic [15:0] wl_or, output logic [7:0] din,
                             output logic stable, output logic excl, output logic acc_ok);
        int t;
        wp = 0; rp = 0; wl_or = '0; din = '0; stable = 1'b1; excl = 1'b1;
        acc_ok = 1'b1; lat = 0; rdata = '0; err = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.rsp_ready = 1'b0;
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin acc_ok = 1'b0; bus.req_valid = 1'b0; return; end
        @(negedge clk);
        // Keep a competing request pending; it must not be taken mid-access.
        bus.req_addr = ~addr; bus.req_wdata = ~wdata; bus.req_we = ~we;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 200) begin
            if (bus.write_pulse === 1'b1) begin wp++; din = bus.sram_datain; end
            if (bus.read_pulse === 1'b1) rp++;
            if (!$onehot0(bus.wl) || (bus.read_pulse && bus.write_pulse)) excl = 1'b0;
            if (bus.req_ready !== 1'b0) stable = 1'b0;
            wl_or |= bus.wl;
            @(negedge clk); lat++;
        end
        if (lat >= 200) begin acc_ok = 1'b0; bus.req_valid = 1'b0; return; end
        rdata = bus.rsp_rdata; err = bus.rsp_err;
        if (bus.wl !== 16'h0) stable = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rdata || bus.rsp_err !== err ||
                bus.req_ready !== 1'b0 || bus.wl !== 16'h0) stable = 1'b0;
        end
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
        @(negedge clk);
        if (bus.rsp_valid !== 1'b0) stable = 1'b0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.wl, bus.read_pulse, bus.write_pulse, bus.sram_datain, bus.req_ready,
             bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== '0) begin
            n_err++; $display("FAIL reset_values: outputs not all zero, wl=%h rdy=%b", bus.wl, bus.req_ready);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.req_ready !== 1'b1 || bus.wl !== 16'h0) begin
            n_err++; $display("FAIL idle_after_reset: req_ready=%b wl=%h, want 1 and 0000", bus.req_ready, bus.wl);
        end
    endtask

    task automatic test_write_read();
        int lat, wp, rp; logic [7:0] rd, din; logic err, st, ex, ok; logic [15:0] wlo;
        do_access(1'b1, 4'd3, 8'hA5, 0, lat, rd, err, wp, rp, wlo, din, st, ex, ok);
        ref_mem[3] = 8'hA5;
        n_vec++;
        if (!ok || wlo !== 16'h0008 || wp != P || din !== 8'hA5 || lat != exp_lat(1'b1)) begin
            n_err++; $display("FAIL wr_a5: wl=%h wp=%0d din=%h lat=%0d, want 0008 %0d a5 %0d", wlo, wp, din, lat, P, exp_lat(1'b1));
        end
        do_access(1'b0, 4'd3, 8'h00, 0, lat, rd, err, wp, rp, wlo, din, st, ex, ok);
        n_vec++;
        if (!ok || rd !== ref_mem[3] || lat != exp_lat(1'b0) || rp != P || wp != 0) begin
            n_err++; $display("FAIL rd_a5: rdata=%h lat=%0d rp=%0d, want %h %0d %0d", rd, lat, rp, ref_mem[3], exp_lat(1'b0), P);
        end
    endtask

    task automatic test_one_hot_corners();
        logic       t_we   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] t_addr [4] = '{4'd0, 4'd15, 4'd0, 4'd15};
        logic [7:0] t_data [4] = '{8'h3C, 8'hC3, 8'h00, 8'h00};
        int lat, wp, rp; logic [7:0] rd, din; logic err, st, ex, ok; logic [15:0] wlo;
        for (int k = 0; k < 4; k++) begin
            do_access(t_we[k], t_addr[k], t_data[k], 0, lat, rd, err, wp, rp, wlo, din, st, ex, ok);
            if (t_we[k]) ref_mem[t_addr[k]] = t_data[k];
            n_vec++;
            if (!ok || !ex || wlo !== (16'h1 << t_addr[k]) ||
                rd !== (t_we[k] ? 8'h00 : ref_mem[t_addr[k]])) begin
                n_err++; $display("FAIL corner_%0d: wl=%h rdata=%h excl=%b, want %h %h", k, wlo, rd, ex,
                                  16'h1 << t_addr[k], t_we[k] ? 8'h00 : ref_mem[t_addr[k]]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat, wp, rp; logic [7:0] rd, din; logic err, st, ex, ok; logic [15:0] wlo;
        do_access(1'b1, 4'd6, 8'h5A, 0, lat, rd, err, wp, rp, wlo, din, st, ex, ok);
        ref_mem[6] = 8'h5A;
        do_access(1'b0, 4'd6, 8'h00, 10, lat, rd, err, wp, rp, wlo, din, st, ex, ok);
        n_vec++;
        if (!ok || !st || rd !== 8'h5A || wlo !== 16'h0040) begin
            n_err++; $display("FAIL backpressure: stable=%b rdata=%h wl=%h, want 1 5a 0040", st, rd, wlo);
        end
    endtask

    task automatic test_random();
        int lat, wp, rp, hold; logic [7:0] rd, din, wd; logic err, st, ex, ok, we;
        logic [15:0] wlo; logic [3:0] a;
        for (int k = 0; k < 24; k++) begin
            we = (k < 6) ? 1'b1 : 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 15)); wd = 8'($urandom); hold = $urandom_range(0, 3);
            do_access(we, a, wd, hold, lat, rd, err, wp, rp, wlo, din, st, ex, ok);
            n_vec++;
            if (!ok || lat != exp_lat(we) || rd !== (we ? 8'h00 : ref_mem[a]) || err !== 1'b0 ||
                wp != (we ? P : 0) || rp != ((!we || VERIFY) ? P : 0) || wlo !== (16'h1 << a) ||
                (we && din !== wd) || !st || !ex) begin
                n_err++; $display("FAIL rand_%0d we=%b a=%0d: lat=%0d rd=%h err=%b wp=%0d rp=%0d wl=%h din=%h st=%b ex=%b, want lat=%0d rd=%h din=%h",
                                  k, we, a, lat, rd, err, wp, rp, wlo, din, st, ex, exp_lat(we),
                                  we ? 8'h00 : ref_mem[a], wd);
            end
            if (we) ref_mem[a] = wd;
        end
    endtask

    task automatic test_back_to_back();
        int acc_t [4]; int k; int t;
        k = 0; t = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.rsp_ready = 1'b1;
        bus.req_addr = 4'($urandom_range(0, 15));
        while (k < 4 && t < 200) begin
            if (bus.req_ready === 1'b1) begin acc_t[k] = cyc; k++; end
            @(negedge clk); t++;
        end
        bus.req_valid = 1'b0;
        repeat (exp_lat(1'b0) + 3) @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_vec++;
        if (k != 4) begin
            n_err++; $display("FAIL b2b_count: accepted %0d, want 4", k);
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_vec++;
                if (acc_t[i] - acc_t[i-1] != exp_lat(1'b0) + 1) begin
                    n_err++; $display("FAIL b2b_period_%0d: %0d cycles, want %0d", i, acc_t[i] - acc_t[i-1], exp_lat(1'b0) + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int t; int lat, wp, rp; logic [7:0] rd, din; logic err, st, ex, ok; logic [15:0] wlo;
        logic seen;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd9; bus.req_wdata = 8'h11;
        t = 0;
        while (bus.write_pulse !== 1'b1 && t < 50) begin
            @(negedge clk); t++;
            if (bus.req_ready === 1'b0) bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        n_vec++;
        if (t >= 50) begin
            n_err++; $display("FAIL abort_no_pulse: write_pulse never rose, want 1");
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (bus.write_pulse !== 1'b0 || bus.wl !== 16'h0 || bus.read_pulse !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL abort_async: wp=%b wl=%h rsp_valid=%b, want 0 0000 0", bus.write_pulse, bus.wl, bus.rsp_valid);
        end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (bus.rsp_valid !== 1'b0) seen = 1'b1; end
        n_vec++;
        if (seen || bus.req_ready !== 1'b1) begin
            n_err++; $display("FAIL abort_no_rsp: rsp_seen=%b req_ready=%b, want 0 1", seen, bus.req_ready);
        end
        do_access(1'b1, 4'd9, 8'h66, 0, lat, rd, err, wp, rp, wlo, din, st, ex, ok);
        ref_mem[9] = 8'h66;
        do_access(1'b0, 4'd9, 8'h00, 0, lat, rd, err, wp, rp, wlo, din, st, ex, ok);
        n_vec++;
        if (!ok || rd !== ref_mem[9] || lat != exp_lat(1'b0)) begin
            n_err++; $display("FAIL abort_recover: rdata=%h lat=%0d, want %h %0d", rd, lat, ref_mem[9], exp_lat(1'b0));
        end
    endtask

`ifdef SRAM_WRITE_VERIFY_EN
    task automatic test_write_verify();
        int lat, wp, rp; logic [7:0] rd, din; logic err, st, ex, ok; logic [15:0] wlo;
        stuck_b0 = 1'b1;
        do_access(1'b1, 4'd5, 8'h77, 0, lat, rd, err, wp, rp, wlo, din, st, ex, ok);
        n_vec++;
        if (!ok || err !== 1'b1 || lat != 9 || rd !== 8'h00) begin
            n_err++; $display("FAIL verify_stuck: err=%b lat=%0d rdata=%h, want 1 9 00", err, lat, rd);
        end
        stuck_b0 = 1'b0;
        do_access(1'b1, 4'd5, 8'h77, 0, lat, rd, err, wp, rp, wlo, din, st, ex, ok);
        ref_mem[5] = 8'h77;
        n_vec++;
        if (!ok || err !== 1'b0 || lat != 9) begin
            n_err++; $display("FAIL verify_clean: err=%b lat=%0d, want 0 9", err, lat);
        end
    endtask
`endif

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; stuck_b0 = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_one_hot_corners();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid_pulse();
`ifdef SRAM_WRITE_VERIFY_EN
        test_write_verify();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
